// File: rtl/sum_pkg.sv
// rtl/sum_pkg.sv - shared types and constants for the sum adder family
//
// Purpose: sequencer state encoding and nibble width used by sum_seq_ctrl.
// Ports: none (package).
package sum_pkg;

  localparam int NIBBLE_W = 4;

  // 2'b11 is unused; the sequencer treats it as IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADD  = 2'b01,
    ST_DONE = 2'b10
  } seq_state_t;

endpackage

// File: rtl/sum4_v2.sv
// rtl/sum4_v2.sv - 4-bit ripple-carry adder
//
// Purpose: combinational 4-bit adder with carry in and carry out.
// Ports:
//   S     out 4  sum nibble
//   c_out out 1  carry out of bit 3
//   A     in  4  addend
//   B     in  4  addend
//   c_in  in  1  carry into bit 0
module sum4_v2 (
  output logic [3:0] S,
  output logic       c_out,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       c_in
);

  logic cy;

  // Carry ripples bit by bit; cy holds the carry into the current bit.
  always_comb begin
    S  = '0;
    cy = c_in;
    for (int i = 0; i < 4; i++) begin
      S[i] = A[i] ^ B[i] ^ cy;
      cy   = (A[i] & B[i]) | (cy & (A[i] ^ B[i]));
    end
    c_out = cy;
  end

endmodule

// File: rtl/sum_seq_ctrl.sv
// rtl/sum_seq_ctrl.sv - nibble-serial wide adder sequencer around sum4_v2
//
// Purpose: latches two W-bit operands on start and adds them one nibble per
// clock through a single sum4_v2, LSB nibble first, then pulses done.
// Ports:
//   clk    in  1  system clock, rising edge
//   rst_n  in  1  asynchronous active-low reset
//   start  in  1  request, honoured only in IDLE
//   A, B   in  W  operands, sampled on the accepting edge
//   c_in   in  1  carry into nibble 0, sampled on the accepting edge
//   S      out W  registered sum (final while done is high)
//   c_out  out 1  registered carry out of the MSB nibble
//   ovf    out 1  registered two's-complement overflow
//   busy   out 1  high whenever not IDLE
//   done   out 1  one-cycle completion pulse
module sum_seq_ctrl
  import sum_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [NIBBLE_W*NIBBLES-1:0] A,
  input  logic [NIBBLE_W*NIBBLES-1:0] B,
  input  logic                        c_in,
  output logic [NIBBLE_W*NIBBLES-1:0] S,
  output logic                        c_out,
  output logic                        ovf,
  output logic                        busy,
  output logic                        done
);

  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int CW = $clog2(NIBBLES);
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  seq_state_t state, next_state;

  logic [W-1:0]        a_sr, b_sr;
  logic                carry;
  logic [CW-1:0]       cnt;
  logic                sign_a, sign_b;
  logic [NIBBLE_W-1:0] sum_nib;
  logic                nib_cout;

  sum4_v2 u_add (
    .S     (sum_nib),
    .c_out (nib_cout),
    .A     (a_sr[NIBBLE_W-1:0]),
    .B     (b_sr[NIBBLE_W-1:0]),
    .c_in  (carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = ST_IDLE;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: next_state = start ? ST_ADD : ST_IDLE;
      ST_ADD: begin
        busy       = 1'b1;
        next_state = (cnt == LAST) ? ST_DONE : ST_ADD;
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      S      <= '0;
      c_out  <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sr   <= A;
            b_sr   <= B;
            carry  <= c_in;
            cnt    <= '0;
            sign_a <= A[W-1];
            sign_b <= B[W-1];
            S      <= '0;
            c_out  <= 1'b0;
            ovf    <= 1'b0;
          end
        end
        ST_ADD: begin
          // New nibbles enter at the top, so after NIBBLES shifts nibble 0
          // has reached the bottom of S.
          S     <= {sum_nib, S[W-1:NIBBLE_W]};
          a_sr  <= a_sr >> NIBBLE_W;
          b_sr  <= b_sr >> NIBBLE_W;
          carry <= nib_cout;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            c_out <= nib_cout;
            // The last nibble's MSB is the result sign bit.
            ovf   <= (sign_a == sign_b) && (sum_nib[NIBBLE_W-1] != sign_a);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sum_seq_ctrl.sv
// tb/tb_sum_seq_ctrl.sv - self-checking bench for sum_seq_ctrl
module tb_sum_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] A, B;
  logic        c_in;
  logic [15:0] S;
  logic        c_out, ovf, busy, done;

  int checks   = 0;
  int failures = 0;

  sum_seq_ctrl #(.NIBBLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .c_in  (c_in),
    .S     (S),
    .c_out (c_out),
    .ovf   (ovf),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_S"}, 32'(S), 32'h0);
    check({tag, "_c_out"}, 32'(c_out), 32'h0);
    check({tag, "_ovf"}, 32'(ovf), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_done"}, 32'(done), 32'h0);
  endtask

  // Called at a falling edge with the DUT idle; returns at a falling edge idle.
  // With noise set, start/A/B/c_in are scrambled during ADD and DONE.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input bit noise);
    int          lat;
    int          sum_signed;
    logic [16:0] full;
    logic [15:0] exp_s;
    logic        exp_c, exp_v;

    full       = {1'b0, a} + {1'b0, b} + 17'(ci);
    exp_s      = full[15:0];
    exp_c      = full[16];
    sum_signed = int'($signed(a)) + int'($signed(b)) + int'(ci);
    exp_v      = (sum_signed > 32767) || (sum_signed < -32768);

    A = a; B = b; c_in = ci; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_accept", 32'(busy), 32'h1);
    check("done_after_accept", 32'(done), 32'h0);
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      if (noise) begin
        start = 1'($urandom);
        A     = 16'($urandom);
        B     = 16'($urandom);
        c_in  = 1'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'd4);
    check("S", 32'(S), 32'(exp_s));
    check("c_out", 32'(c_out), 32'(exp_c));
    check("ovf", 32'(ovf), 32'(exp_v));
    check("busy_in_done", 32'(busy), 32'h1);
    if (noise) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done_pulse_end", 32'(done), 32'h0);
    check("busy_end", 32'(busy), 32'h0);
    @(negedge clk);
    check("no_requeue_busy", 32'(busy), 32'h0);
    check("S_hold", 32'(S), 32'(exp_s));
  endtask

  int done_seen;

  initial begin
    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; c_in = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_init");
    rst_n = 1'b1;

    run_op(16'h0000, 16'h0000, 1'b1, 1'b0);

    // Asynchronous reset with no clock edge in between.
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    run_op(16'h8000, 16'h8000, 1'b0, 1'b0);
    run_op(16'h1234, 16'h1111, 1'b0, 1'b1);

    // Abort after E2: no done may appear, then first edge after release accepts.
    A = 16'hABCD; B = 16'h4321; c_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("abort_reset");
    done_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    check("abort_no_done", 32'(done_seen), 32'h0);
    rst_n = 1'b1;
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
